alu_cmd_issuer: RTL
===================

Name: alu_cmd_issuer

Overview:
Sequential front-end that drives the team's 8-bit signed ALU datapath from a command stream.
- Accepts (op, A, B, tag) commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle to an internal combinational execute unit, registers result and overflow, and returns them over a valid/ready result handshake.
- Keeps a sticky overflow flag and an issued-operation counter for status readback.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2.
TAG_W, 4, width of the opaque tag carried from command to result.
CNT_W, 16, width of the issued-operation counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  issuer can accept command
cmd_op  in  3  opcode 0..7
cmd_a  in  8  signed operand A
cmd_b  in  8  signed operand B
cmd_tag  in  TAG_W  tag returned with result
res_valid  out  1  result present
res_ready  in  1  consumer accepts result
res_z  out  8  signed result
res_of  out  1  signed overflow for this result
res_err  out  1  illegal opcode (6 or 7)
res_tag  out  TAG_W  tag of the originating command
of_sticky  out  1  set by any issued result with res_of=1
clr_sticky  in  1  clears of_sticky
op_count  out  CNT_W  number of commands issued to the execute unit

Behaviour:
- Reset (async assert, sync release): FIFO empty, res_valid=0, res_z=0, res_of=0, res_err=0, res_tag=0, of_sticky=0, op_count=0, cmd_ready=1. In-flight commands and results are discarded with no partial output.
- Accept: push on rising edge when cmd_valid&&cmd_ready. cmd_ready = !fifo_full; it does not depend on a same-cycle pop.
- Issue: head is popped, executed and loaded into the result register on an edge when the FIFO is non-empty and (!res_valid || res_ready).
- Latency: command accepted at edge N with an empty pipeline gives res_valid=1 after edge N+1.
- Throughput: one result per cycle while res_ready=1.
- Result hold: res_* are stable while res_valid && !res_ready. A handshake without a refill clears res_valid. Data fields keep their last value.
- Execute, all 8-bit two's complement with wrap:
  - op0 Z=A+B; OF=(A7&B7&~Z7)|(~A7&~B7&Z7).
  - op1 Z=A-B; OF=(A7&~B7&~Z7)|(~A7&B7&Z7).
  - op2 Z=signed max(A,B); op3 Z=signed min(A,B); op4 Z=A<<2, zero fill; op5 Z=B>>>3, sign fill. OF=0 for op2..op5.
  - op6/op7: Z=0, OF=0, err=1. Still issued and counted.
- of_sticky: set on issue edge when OF=1. clr_sticky clears it. A set on the same edge as clr_sticky wins.
- op_count: +1 per issue edge, wraps at 2^CNT_W.
- FIFO: circular pointers with wrap at DEPTH-1. Simultaneous push and pop with the FIFO non-full keeps occupancy. Push is ignored when full (cmd_ready=0). Pop is never attempted when empty.
- Capacity under full backpressure: DEPTH commands in the FIFO plus 1 in the result register.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MAX=2, OP_MIN=3, OP_SHL2=4, OP_SRA3=5;
  - data width constant DATA_W=8;
  - a command struct typedef {op, a, b, tag}.
- One sub-module, alu_exec: purely combinational op/A/B -> Z/OF/err, reusable by the bench as a golden model.
- FIFO is inline; no separate module.

Test Plan:
- Add overflow: op0 A=100 B=50 tag=3 -> res_z=0x96 (-106), res_of=1, res_tag=3, of_sticky=1 after the issue edge, op_count=1.
- Sub overflow and shifts:
  - op1 A=-128 B=1 -> res_z=0x7F, res_of=1.
  - op5 B=0xF0 -> res_z=0xFE.
  - op4 A=0x41 -> res_z=0x04, res_of=0.
- Min/max and illegal:
  - op2 A=-3 B=5 -> 5.
  - op3 A=-3 B=5 -> -3.
  - op7 -> res_z=0, res_err=1, op_count increments.
- Backpressure, DEPTH=4, res_ready=0, cmd_valid held high: exactly 5 accepted, then cmd_ready=0. Release res_ready -> 5 results in order on 5 consecutive cycles with original tags.
- Streaming, res_ready=1, one command per cycle for 20 cycles: one result per cycle, 2-edge latency, op_count=20, cmd_ready never drops.
- Reset mid-stream with 3 commands queued: all outputs return to reset values immediately; no stale result after release. clr_sticky asserted on the same edge as an overflow issue leaves of_sticky=1.

Source files
------------

// File: rtl/alu_cmd_issuer_pkg.sv
// Shared types and constants for the ALU command issuer and its execute unit.
package alu_cmd_issuer_pkg;

    localparam int DATA_W    = 8;
    localparam int OP_W      = 3;
    // Tags are carried zero-extended to this width inside the command buffer.
    localparam int MAX_TAG_W = 16;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_MAX  = 3'd2;
    localparam logic [OP_W-1:0] OP_MIN  = 3'd3;
    localparam logic [OP_W-1:0] OP_SHL2 = 3'd4;
    localparam logic [OP_W-1:0] OP_SRA3 = 3'd5;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic [MAX_TAG_W-1:0] tag;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command and result handshakes between a command producer (master) and the issuer (slave).
interface alu_cmd_issuer_if
    import alu_cmd_issuer_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [OP_W-1:0]       cmd_op;
    logic [DATA_W-1:0]     cmd_a;
    logic [DATA_W-1:0]     cmd_b;
    logic [TAG_W-1:0]      cmd_tag;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_W-1:0]     res_z;
    logic                  res_of;
    logic                  res_err;
    logic [TAG_W-1:0]      res_tag;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, res_ready,
        input  cmd_ready, res_valid, res_z, res_of, res_err, res_tag
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, res_ready,
        output cmd_ready, res_valid, res_z, res_of, res_err, res_tag
    );

endinterface

// File: rtl/alu_exec.sv
// Combinational 8-bit signed execute unit: op/A/B -> Z, signed overflow, illegal-op flag.
module alu_exec
    import alu_cmd_issuer_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] z,
    output logic              of,
    output logic              err
);
    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        z   = '0;
        of  = 1'b0;
        err = 1'b0;
        case (op)
            OP_ADD: begin
                z  = sum;
                of = (a[MSB] & b[MSB] & ~sum[MSB]) | (~a[MSB] & ~b[MSB] & sum[MSB]);
            end
            OP_SUB: begin
                z  = diff;
                of = (a[MSB] & ~b[MSB] & ~diff[MSB]) | (~a[MSB] & b[MSB] & diff[MSB]);
            end
            OP_MAX:  z = ($signed(a) > $signed(b)) ? a : b;
            OP_MIN:  z = ($signed(a) < $signed(b)) ? a : b;
            OP_SHL2: z = a << 2;
            OP_SRA3: z = $signed(b) >>> 3;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands in a small FIFO, issues one per cycle through alu_exec and
// returns registered results with a sticky overflow flag and an issue counter.
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_issuer_if.slave  bus,
    input  logic             clr_sticky,
    output logic             of_sticky,
    output logic [CNT_W-1:0] op_count
);
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] FULL_N = DEPTH[AW:0];

    cmd_t              mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    cmd_t              wr_cmd;
    cmd_t              head;
    logic [DATA_W-1:0] ex_z;
    logic              ex_of;
    logic              ex_err;
    logic              unused_tag_hi;

    assign full          = (count == FULL_N);
    assign empty         = (count == '0);
    assign bus.cmd_ready = !full;
    assign push          = bus.cmd_valid && !full;
    // Refill the result register whenever it is empty or being drained this edge.
    assign pop           = !empty && (!bus.res_valid || bus.res_ready);

    assign wr_cmd = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b,
                      tag: MAX_TAG_W'(bus.cmd_tag)};
    assign head   = mem[rd_ptr];
    assign unused_tag_hi = ^(head.tag >> TAG_W);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_cmd;
    end

    alu_exec u_exec (
        .op  (head.op),
        .a   (head.a),
        .b   (head.b),
        .z   (ex_z),
        .of  (ex_of),
        .err (ex_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.res_valid <= 1'b0;
            bus.res_z     <= '0;
            bus.res_of    <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.res_tag   <= '0;
            of_sticky     <= 1'b0;
            op_count      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;

            if (pop) begin
                bus.res_valid <= 1'b1;
                bus.res_z     <= ex_z;
                bus.res_of    <= ex_of;
                bus.res_err   <= ex_err;
                bus.res_tag   <= head.tag[TAG_W-1:0];
                op_count      <= op_count + 1'b1;
            end else if (bus.res_ready) begin
                bus.res_valid <= 1'b0;
            end

            // A new overflow outranks a clear on the same edge.
            if (pop && ex_of)    of_sticky <= 1'b1;
            else if (clr_sticky) of_sticky <= 1'b0;
        end
    end

endmodule
